// File: rtl/i2s_pkg.sv
// Shared I2S package: bus width, default FIFO geometry, and the codec state
// encoding that the codec and its benches share.
package i2s_pkg;

   localparam int I2S_BUS_W              = 32;
   localparam int I2S_DEFAULT_DATA_WIDTH = 16;
   localparam int I2S_DEFAULT_DEPTH_LOG2 = 5;

   // Codec controller states, exported so benches can decode the codec FSM
   typedef enum logic [2:0] {
      IDLE,
      WAIT_CLK,
      TRX_DATA,
      RX_WRITE,
      SYNC
   } i2s_state_t;

   // Number of words held by a FIFO with the given address width
   function automatic int i2s_fifo_depth(input int depth_log2);
      return 1 << depth_log2;
   endfunction

endpackage

// File: rtl/i2s_fifo_mem.sv
// Simple dual-port sample memory: one write port and one synchronous read
// port, written so that synthesis maps it onto block RAM (EBR). No reset on
// the array or the read register; the owner gates stale read data itself.
module i2s_fifo_mem
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH = I2S_DEFAULT_DATA_WIDTH,
   parameter int ADDR_W     = I2S_DEFAULT_DEPTH_LOG2
) (
   input  logic                  sysclk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

   // Write port: store the producer word at the write address
   always_ff @(posedge sysclk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read port: registered read, only updated when a word is popped
   always_ff @(posedge sysclk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/i2s_tx_sample_fifo.sv
// Transmit sample FIFO sitting in front of the I2S codec. Producer samples
// arrive on a valid/ready port; each codec buffer-read strobe reloads tx_data
// one sysclk later. An empty FIFO at strobe time is an underrun: it is flagged
// and counted, never stalled.
// Build option: I2S_FIFO_UNDERRUN_HOLD_EN - when defined, an underrun keeps the
// previous tx_data (last sample repeats); otherwise tx_data drops to zero.
module i2s_tx_sample_fifo
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH = I2S_DEFAULT_DATA_WIDTH,
   parameter int DEPTH_LOG2 = I2S_DEFAULT_DEPTH_LOG2
) (
   input  logic                  sysclk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_strobe,
   output logic [I2S_BUS_W-1:0]  tx_data,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  empty,
   output logic                  underrun,
   input  logic                  underrun_clr,
   output logic [15:0]           underrun_cnt
);

   localparam int PTR_W = DEPTH_LOG2 + 1;
   localparam logic [PTR_W-1:0] FULL_LEVEL = PTR_W'(i2s_fifo_depth(DEPTH_LOG2));

`ifdef I2S_FIFO_UNDERRUN_HOLD_EN
   localparam bit UNDERRUN_HOLD = 1'b1;
`else
   localparam bit UNDERRUN_HOLD = 1'b0;
`endif

   logic                  active;
   logic                  push;
   logic                  pop;
   logic                  underrun_hit;
   logic [PTR_W-1:0]      wp;
   logic [PTR_W-1:0]      rp;
   logic [PTR_W-1:0]      wp_next;
   logic [PTR_W-1:0]      rp_next;
   logic [PTR_W-1:0]      level_next;
   logic                  data_valid;
   logic [DATA_WIDTH-1:0] rd_data;

   // Reset and a low enable both flush everything, so one qualifier covers both.
   // Pop and underrun decisions use the registered empty, which always matches
   // the current pointer pair, so a word pushed in cycle N is poppable in N+1.
   always_comb begin
      active       = reset && enable;
      push         = active && wr_valid && wr_ready;
      pop          = active && rd_strobe && !empty;
      underrun_hit = active && rd_strobe && empty;
   end

   // Next pointer values and the resulting fill level; the extra pointer MSB
   // makes the plain difference range over 0..2**DEPTH_LOG2
   always_comb begin
      wp_next = wp;
      rp_next = rp;
      if (push) begin
         wp_next = wp + PTR_W'(1);
      end
      if (pop) begin
         rp_next = rp + PTR_W'(1);
      end
      level_next = wp_next - rp_next;
   end

   // Pointer state plus registered level/empty/ready derived from the next pointers
   always_ff @(posedge sysclk) begin
      if (!active) begin
         wp       <= '0;
         rp       <= '0;
         level    <= '0;
         empty    <= 1'b1;
         wr_ready <= 1'b0;
      end else begin
         wp       <= wp_next;
         rp       <= rp_next;
         level    <= level_next;
         empty    <= (level_next == '0);
         wr_ready <= (level_next != FULL_LEVEL);
      end
   end

   // Tracks whether the memory read register holds a sample that should drive
   // the codec; cleared by flush, and by an underrun unless hold mode is built in
   always_ff @(posedge sysclk) begin
      if (!active) begin
         data_valid <= 1'b0;
      end else if (pop) begin
         data_valid <= 1'b1;
      end else if (underrun_hit && !UNDERRUN_HOLD) begin
         data_valid <= 1'b0;
      end
   end

   // Sticky underrun flag and saturating counter; an explicit clear beats a
   // coincident underrun strobe
   always_ff @(posedge sysclk) begin
      if (!active) begin
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else if (underrun_clr) begin
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else if (underrun_hit) begin
         underrun <= 1'b1;
         if (underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
         end
      end
   end

   // The read register only advances on a pop, so it naturally holds between
   // strobes; gating with data_valid gives zero after flush or a silent underrun
   always_comb begin
      tx_data = data_valid ? I2S_BUS_W'(rd_data) : '0;
   end

   i2s_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (DEPTH_LOG2)
   ) u_mem (
      .sysclk  (sysclk),
      .wr_en   (push),
      .wr_addr (wp[DEPTH_LOG2-1:0]),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_addr (rp[DEPTH_LOG2-1:0]),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_i2s_tx_sample_fifo.sv
// Directed self-checking bench for i2s_tx_sample_fifo (default geometry:
// 16-bit samples, 32 words). Expected fill value follows
// I2S_FIFO_UNDERRUN_HOLD_EN when the bench is built with it.
module tb_i2s_tx_sample_fifo;

   logic        sysclk;
   logic        reset;
   logic        enable;
   logic        wr_valid;
   logic        wr_ready;
   logic [15:0] wr_data;
   logic        rd_strobe;
   logic [31:0] tx_data;
   logic [5:0]  level;
   logic        empty;
   logic        underrun;
   logic        underrun_clr;
   logic [15:0] underrun_cnt;

   int checks = 0;
   int errors = 0;

`ifdef I2S_FIFO_UNDERRUN_HOLD_EN
   localparam logic [31:0] FILL_AFTER_7FFF = 32'h0000_7FFF;
`else
   localparam logic [31:0] FILL_AFTER_7FFF = 32'h0000_0000;
`endif

   i2s_tx_sample_fifo #(
      .DATA_WIDTH (16),
      .DEPTH_LOG2 (5)
   ) dut (
      .sysclk       (sysclk),
      .reset        (reset),
      .enable       (enable),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .rd_strobe    (rd_strobe),
      .tx_data      (tx_data),
      .level        (level),
      .empty        (empty),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .underrun_cnt (underrun_cnt)
   );

   // Free-running 100 MHz system clock
   initial begin
      sysclk = 1'b0;
      forever #5 sysclk = ~sysclk;
   end

   // Compare one observed value against its expected value and count it
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, let the next rising edge take them, settle 1 ns
   task automatic applyStimulus(input logic v, input logic [15:0] d, input logic s, input logic clr);
      wr_valid     = v;
      wr_data      = d;
      rd_strobe    = s;
      underrun_clr = clr;
      @(posedge sysclk);
      #1;
   endtask

   // Build level 5 with a live tx_data and a set underrun, then flush by
   // enable-low or by reset and confirm everything clears and strobes are ignored
   task automatic runFlushCase(input bit use_reset, input string name);
      applyStimulus(0, 16'h0000, 1, 0);
      checkOutput({name, "_pre_underrun"}, 32'(underrun_cnt), 32'd1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, 16'h5000 + 16'(i), 0, 0);
      end
      applyStimulus(0, 16'h0000, 1, 0);
      checkOutput({name, "_pre_tx"}, tx_data, 32'h0000_5000);
      checkOutput({name, "_pre_level"}, 32'(level), 32'd5);
      if (use_reset) reset = 1'b0;
      else           enable = 1'b0;
      applyStimulus(0, 16'h0000, 0, 0);
      checkOutput({name, "_level"}, 32'(level), 32'd0);
      checkOutput({name, "_tx"}, tx_data, 32'd0);
      checkOutput({name, "_ready"}, 32'(wr_ready), 32'd0);
      checkOutput({name, "_empty"}, 32'(empty), 32'd1);
      checkOutput({name, "_ucnt"}, 32'(underrun_cnt), 32'd0);
      applyStimulus(1, 16'hDEAD, 1, 0);
      applyStimulus(1, 16'hDEAD, 1, 0);
      checkOutput({name, "_ign_level"}, 32'(level), 32'd0);
      checkOutput({name, "_ign_under"}, 32'(underrun), 32'd0);
      checkOutput({name, "_ign_tx"}, tx_data, 32'd0);
      reset  = 1'b1;
      enable = 1'b1;
      applyStimulus(0, 16'h0000, 0, 0);
      checkOutput({name, "_re_ready"}, 32'(wr_ready), 32'd1);
      applyStimulus(1, 16'hABCD, 0, 0);
      applyStimulus(0, 16'h0000, 1, 0);
      checkOutput({name, "_re_tx"}, tx_data, 32'h0000_ABCD);
      checkOutput({name, "_re_level"}, 32'(level), 32'd0);
      checkOutput({name, "_re_under"}, 32'(underrun), 32'd0);
   endtask

   // Main directed sequence
   initial begin
      int  accepted;
      int  sent;
      int  recv;
      int  gap;
      int  cycles;
      int  n_push;
      int  n_pop;
      logic ok;
      logic v;
      logic s;

      reset        = 1'b0;
      enable       = 1'b0;
      wr_valid     = 1'b0;
      wr_data      = '0;
      rd_strobe    = 1'b0;
      underrun_clr = 1'b0;
      repeat (3) applyStimulus(0, 16'h0000, 0, 0);

      // Reset state
      checkOutput("rst_tx", tx_data, 32'd0);
      checkOutput("rst_ready", 32'(wr_ready), 32'd0);
      checkOutput("rst_level", 32'(level), 32'd0);
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_under", 32'(underrun), 32'd0);
      checkOutput("rst_ucnt", 32'(underrun_cnt), 32'd0);

      // Basic push of two words and two spaced pops
      reset  = 1'b1;
      enable = 1'b1;
      applyStimulus(0, 16'h0000, 0, 0);
      checkOutput("en_ready", 32'(wr_ready), 32'd1);
      applyStimulus(1, 16'h1111, 0, 0);
      applyStimulus(1, 16'h2222, 0, 0);
      checkOutput("basic_level2", 32'(level), 32'd2);
      applyStimulus(0, 16'h0000, 1, 0);
      checkOutput("basic_tx1", tx_data, 32'h0000_1111);
      checkOutput("basic_level1", 32'(level), 32'd1);
      checkOutput("basic_nempty", 32'(empty), 32'd0);
      repeat (8) applyStimulus(0, 16'h0000, 0, 0);
      checkOutput("basic_hold", tx_data, 32'h0000_1111);
      applyStimulus(0, 16'h0000, 1, 0);
      checkOutput("basic_tx2", tx_data, 32'h0000_2222);
      checkOutput("basic_level0", 32'(level), 32'd0);
      checkOutput("basic_empty", 32'(empty), 32'd1);

      // Push then strobe on the very next cycle, then underrun
      applyStimulus(1, 16'h7FFF, 0, 0);
      applyStimulus(0, 16'h0000, 1, 0);
      checkOutput("n1_tx", tx_data, 32'h0000_7FFF);
      applyStimulus(0, 16'h0000, 1, 0);
      checkOutput("ur_flag", 32'(underrun), 32'd1);
      checkOutput("ur_cnt1", 32'(underrun_cnt), 32'd1);
      checkOutput("ur_fill", tx_data, FILL_AFTER_7FFF);
      applyStimulus(1, 16'h5555, 1, 0);
      checkOutput("ur_cnt2", 32'(underrun_cnt), 32'd2);
      checkOutput("ur_push_level", 32'(level), 32'd1);
      applyStimulus(0, 16'h0000, 1, 0);
      checkOutput("ur_push_tx", tx_data, 32'h0000_5555);
      applyStimulus(0, 16'h0000, 1, 1);
      checkOutput("clr_flag", 32'(underrun), 32'd0);
      checkOutput("clr_cnt", 32'(underrun_cnt), 32'd0);

      // Fill to full with wr_valid held high
      accepted = 0;
      for (int i = 0; i < 40; i++) begin
         ok = wr_ready;
         applyStimulus(1, 16'h0100 + accepted[15:0], 0, 0);
         if (ok) accepted++;
      end
      checkOutput("full_accepted", 32'(accepted), 32'd32);
      checkOutput("full_level", 32'(level), 32'd32);
      checkOutput("full_ready", 32'(wr_ready), 32'd0);
      applyStimulus(1, 16'h0120, 1, 0);
      checkOutput("full_pop_tx", tx_data, 32'h0000_0100);
      checkOutput("full_pop_ready", 32'(wr_ready), 32'd1);
      checkOutput("full_pop_level", 32'(level), 32'd31);
      applyStimulus(1, 16'h0120, 0, 0);
      checkOutput("full_w33_level", 32'(level), 32'd32);
      checkOutput("full_w33_ready", 32'(wr_ready), 32'd0);
      for (int k = 1; k <= 32; k++) begin
         applyStimulus(0, 16'h0000, 1, 0);
         checkOutput("full_drain", tx_data, 32'h0000_0100 + 32'(k));
         applyStimulus(0, 16'h0000, 0, 0);
      end
      checkOutput("full_drain_empty", 32'(empty), 32'd1);

      // Simultaneous push and pop at level 3
      n_push = 0;
      n_pop  = 0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 16'h3000 + n_push[15:0], 0, 0);
         n_push++;
      end
      checkOutput("pp_level_start", 32'(level), 32'd3);
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1, 16'h3000 + n_push[15:0], 1, 0);
         n_push++;
         checkOutput("pp_tx", tx_data, 32'h0000_3000 + 32'(n_pop));
         n_pop++;
         checkOutput("pp_level", 32'(level), 32'd3);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 16'h0000, 1, 0);
         checkOutput("pp_drain", tx_data, 32'h0000_3000 + 32'(n_pop));
         n_pop++;
      end
      checkOutput("pp_empty", 32'(empty), 32'd1);

      // Pointer wrap: 1000 incrementing samples, random strobe spacing >= 2
      sent   = 0;
      recv   = 0;
      gap    = 2;
      cycles = 0;
      while (recv < 1000 && cycles < 20000) begin
         v  = (sent < 1000);
         s  = (gap == 0) && (recv < sent);
         ok = v && wr_ready;
         applyStimulus(v, sent[15:0], s, 0);
         cycles++;
         if (ok) sent++;
         if (s) begin
            checkOutput("wrap_tx", tx_data, 32'(recv[15:0]));
            recv++;
            gap = $urandom_range(1, 4);
         end else if (gap > 0) begin
            gap--;
         end
      end
      checkOutput("wrap_count", 32'(recv), 32'd1000);
      checkOutput("wrap_under", 32'(underrun), 32'd0);
      checkOutput("wrap_ucnt", 32'(underrun_cnt), 32'd0);
      checkOutput("wrap_level", 32'(level), 32'd0);

      // Mid-stream flush by enable low, then by reset
      runFlushCase(1'b0, "en_flush");
      runFlushCase(1'b1, "rst_flush");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
